// File: rtl/ap_sram_target.sv
// On-chip emulation of an async-SRAM device: synchronized pin sampling, block-RAM storage, tri-state read drive.
// Reads drive the bus READ_LATENCY cycles after decode; writes commit two cycles after WE_n/CE_n release.
module ap_sram_target #(
    parameter int ADDR_WIDTH   = 18,
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                  iCLK,
    input  logic                  iRESET_n,
    input  logic [ADDR_WIDTH-1:0] iSRAM_A,
    inout  wire  [15:0]           ioSRAM_D,
    input  logic                  iSRAM_CE_n,
    input  logic                  iSRAM_OE_n,
    input  logic                  iSRAM_WE_n,
    output logic [15:0]           oWR_COUNT,
    output logic [15:0]           oRD_COUNT
);

    localparam int CNT_W = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WRITE      = 2'd1;
    localparam logic [1:0] S_READ_WAIT  = 2'd2;
    localparam logic [1:0] S_READ_DRIVE = 2'd3;

    // control synchronizer bits are ordered {ce_n, oe_n, we_n}
    logic [2:0]            ctl_s1_q, ctl_s1_d, ctl_s2_q, ctl_s2_d;
    logic [ADDR_WIDTH-1:0] a_s1_q, a_s1_d, a_s2_q, a_s2_d;
    logic [15:0]           d_s1_q, d_s1_d, d_s2_q, d_s2_d;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DEPTH_LOG2-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]           wr_data_q, wr_data_d;
    logic [15:0]           dout_q, dout_d;
    logic [15:0]           wr_count_q, wr_count_d;
    logic [15:0]           rd_count_q, rd_count_d;
    logic                  mem_we;

    logic [15:0] mem [0:(1<<DEPTH_LOG2)-1];

    logic s_ce_n, s_oe_n, s_we_n;
    logic drive_en;

    assign s_ce_n = ctl_s2_q[2];
    assign s_oe_n = ctl_s2_q[1];
    assign s_we_n = ctl_s2_q[0];

    always_comb begin
        ctl_s1_d = {iSRAM_CE_n, iSRAM_OE_n, iSRAM_WE_n};
        ctl_s2_d = ctl_s1_q;
        a_s1_d   = iSRAM_A;
        a_s2_d   = a_s1_q;
        d_s1_d   = ioSRAM_D;
        d_s2_d   = d_s1_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        dout_d     = dout_q;
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!s_ce_n && !s_we_n) begin
                    state_d = S_WRITE;
                end else if (!s_ce_n && !s_oe_n) begin
                    state_d   = S_READ_WAIT;
                    rd_addr_d = a_s2_q;
                    cnt_d     = CNT_LOAD;
                end
            end
            S_WRITE: begin
                // the last address/data seen while WE was low is what commits
                if (!s_ce_n && !s_we_n) begin
                    wr_addr_d = a_s2_q[DEPTH_LOG2-1:0];
                    wr_data_d = d_s2_q;
                end else begin
                    mem_we     = 1'b1;
                    wr_count_d = wr_count_q + 16'd1;
                    state_d    = S_IDLE;
                end
            end
            S_READ_WAIT: begin
                if (s_ce_n || s_oe_n || !s_we_n) begin
                    state_d = S_IDLE;
                end else if (a_s2_q != rd_addr_q) begin
                    rd_addr_d = a_s2_q;
                    cnt_d     = CNT_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        dout_d     = mem[rd_addr_q[DEPTH_LOG2-1:0]];
                        rd_count_d = rd_count_q + 16'd1;
                        state_d    = S_READ_DRIVE;
                    end
                end
            end
            S_READ_DRIVE: begin
                if (!s_we_n && !s_ce_n) begin
                    state_d = S_WRITE;
                end else if (s_ce_n || s_oe_n) begin
                    state_d = S_IDLE;
                end else if (a_s2_q != rd_addr_q) begin
                    state_d   = S_READ_WAIT;
                    rd_addr_d = a_s2_q;
                    cnt_d     = CNT_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET_n) begin
        if (!iRESET_n) begin
            ctl_s1_q   <= 3'b111;
            ctl_s2_q   <= 3'b111;
            a_s1_q     <= '0;
            a_s2_q     <= '0;
            d_s1_q     <= '0;
            d_s2_q     <= '0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            dout_q     <= 16'h0000;
            wr_count_q <= 16'h0000;
            rd_count_q <= 16'h0000;
        end else begin
            ctl_s1_q   <= ctl_s1_d;
            ctl_s2_q   <= ctl_s2_d;
            a_s1_q     <= a_s1_d;
            a_s2_q     <= a_s2_d;
            d_s1_q     <= d_s1_d;
            d_s2_q     <= d_s2_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            dout_q     <= dout_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    // storage is deliberately unreset so it maps onto block RAM
    always_ff @(posedge iCLK) begin
        if (mem_we) begin
            mem[wr_addr_q] <= wr_data_q;
        end
    end

    // gate on raw pins so the bus is released the moment the initiator lets go
    assign drive_en  = (state_q == S_READ_DRIVE) && !iSRAM_CE_n && !iSRAM_OE_n && iSRAM_WE_n;
    assign ioSRAM_D  = drive_en ? dout_q : 16'hzzzz;
    assign oWR_COUNT = wr_count_q;
    assign oRD_COUNT = rd_count_q;

endmodule

// File: tb/tb_ap_sram_target.sv
// Randomized bench for ap_sram_target: reference memory model plus a read-data scoreboard.
// The bus has a pull-up, so an undriven bus reads as 16'hFFFF (test data never uses that value).
module tb_ap_sram_target;

    localparam int RL = 2;
    localparam int DL = 10;

    logic        clk;
    logic        rst_n;
    logic [17:0] a;
    logic        ce_n, oe_n, we_n;
    logic [15:0] tb_d;
    logic        tb_d_oe;
    tri1  [15:0] sram_d;
    logic [15:0] wr_count, rd_count;

    assign sram_d = tb_d_oe ? tb_d : 16'hzzzz;

    ap_sram_target #(.ADDR_WIDTH(18), .DEPTH_LOG2(DL), .READ_LATENCY(RL)) dut (
        .iCLK(clk), .iRESET_n(rst_n), .iSRAM_A(a), .ioSRAM_D(sram_d),
        .iSRAM_CE_n(ce_n), .iSRAM_OE_n(oe_n), .iSRAM_WE_n(we_n),
        .oWR_COUNT(wr_count), .oRD_COUNT(rd_count)
    );

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] ref_mem [0:(1<<DL)-1];
    bit          ref_written [0:(1<<DL)-1];
    int          widx_q[$];
    int          wr_exp, rd_exp;
    int          checks, errors;
    int          cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_counts();
        check16("wr_count", wr_count, wr_exp[15:0]);
        check16("rd_count", rd_count, rd_exp[15:0]);
    endtask

    task automatic model_write(input logic [17:0] addr, input logic [15:0] data);
        int idx;
        idx = int'(addr[DL-1:0]);
        ref_mem[idx] = data;
        if (!ref_written[idx]) begin
            ref_written[idx] = 1'b1;
            widx_q.push_back(idx);
        end
        wr_exp++;
    endtask

    // a read fetch must first appear on the bus READ_LATENCY+3 edges after the pins were set
    task automatic expect_read(input logic [17:0] addr);
        exp_t e;
        e.data = ref_mem[int'(addr[DL-1:0])];
        e.cyc  = cyc + 3 + RL;
        exp_q.push_back(e);
        rd_exp++;
    endtask

    task automatic end_op();
        ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; tb_d_oe = 1'b0;
        #1;
        check16("release_hiz", sram_d, 16'hFFFF);
        tick(3);
        check_counts();
    endtask

    task automatic do_write(input logic [17:0] addr, input logic [15:0] data, input int hold, input bit oe_low);
        ce_n = 1'b0; we_n = 1'b0; oe_n = !oe_low; a = addr; tb_d = data; tb_d_oe = 1'b1;
        tick(hold);
        model_write(addr, data);
        end_op();
    endtask

    task automatic do_read(input logic [17:0] addr, input bit chg, input logic [17:0] addr2, input int extra);
        ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; a = addr; tb_d_oe = 1'b0;
        if (chg) begin
            tick(1);
            a = addr2;
            expect_read(addr2);
        end else begin
            expect_read(addr);
        end
        tick(RL + 3 + extra);
        end_op();
    endtask

    task automatic read_change(input logic [17:0] addr, input logic [17:0] addr2);
        ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; a = addr; tb_d_oe = 1'b0;
        expect_read(addr);
        tick(RL + 4);
        a = addr2;
        expect_read(addr2);
        tick(RL + 4);
        end_op();
    endtask

    task automatic read_then_write(input logic [17:0] addr, input logic [15:0] data);
        ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; a = addr; tb_d_oe = 1'b0;
        expect_read(addr);
        tick(RL + 4);
        we_n = 1'b0;
        #1;
        check16("we_gate_hiz", sram_d, 16'hFFFF);
        tick(1);
        tb_d = data; tb_d_oe = 1'b1;
        tick(3);
        model_write(addr, data);
        end_op();
    endtask

    function automatic logic [17:0] pick_addr();
        logic [7:0] up;
        int         idx;
        up  = 8'($urandom);
        idx = widx_q[$urandom_range(0, widx_q.size() - 1)];
        return {up, idx[DL-1:0]};
    endfunction

    initial begin
        fork
            begin : monitor
                bit   prev;
                bit   drv;
                exp_t e;
                prev = 1'b0;
                forever begin
                    @(negedge clk);
                    drv = !tb_d_oe && (sram_d !== 16'hFFFF);
                    if (drv && !prev) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_drive: got %h at cycle %0d, expected no drive", sram_d, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            check16("read_data", sram_d, e.data);
                            check_int("read_latency", cyc, e.cyc);
                        end
                    end
                    prev = drv;
                end
            end
            begin : stimulus
                logic [17:0] ra, rb;
                logic [15:0] rd;
                int          r;
                rst_n = 1'b0; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
                a = '0; tb_d = '0; tb_d_oe = 1'b0;
                wr_exp = 0; rd_exp = 0;
                tick(3);
                check16("reset_hiz", sram_d, 16'hFFFF);
                check_counts();
                ce_n = 1'b1; oe_n = 1'b1;
                rst_n = 1'b1;
                tick(3);
                check16("post_reset_hiz", sram_d, 16'hFFFF);
                check_counts();

                do_write(18'h00005, 16'hBEEF, 4, 1'b0);
                do_read(18'h00005, 1'b0, 18'h0, 1);
                do_write(18'h00403, 16'h1234, 4, 1'b0);
                do_read(18'h00003, 1'b0, 18'h0, 2);
                do_write(18'h00006, 16'hCAFE, 4, 1'b0);
                read_change(18'h00005, 18'h00006);
                do_write(18'h00007, 16'h00AA, 4, 1'b1);
                do_read(18'h00007, 1'b0, 18'h0, 1);
                do_write(18'h00008, 16'h1111, 3, 1'b0);
                read_then_write(18'h00008, 16'h0055);
                do_read(18'h20008, 1'b0, 18'h0, 1);

                for (int i = 0; i < 60; i++) begin
                    r = $urandom_range(0, 9);
                    if (r < 4) begin
                        ra = 18'($urandom);
                        rd = 16'($urandom_range(0, 16'hFFFE));
                        do_write(ra, rd, $urandom_range(3, 6), r == 0);
                    end else if (r < 7) begin
                        ra = pick_addr();
                        rb = pick_addr();
                        do_read(ra, r == 6, rb, $urandom_range(1, 3));
                    end else if (r < 9) begin
                        ra = pick_addr();
                        rb = pick_addr();
                        if (rb == ra) rb = ra ^ 18'h00001;
                        if (!ref_written[int'(rb[DL-1:0])]) rb = ra ^ 18'h10000;
                        read_change(ra, rb);
                    end else begin
                        rd = 16'($urandom_range(0, 16'hFFFE));
                        read_then_write(pick_addr(), rd);
                    end
                end

                ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; a = 18'h00005; tb_d_oe = 1'b0;
                expect_read(18'h00005);
                tick(RL + 4);
                rst_n = 1'b0;
                #1;
                check16("reset_mid_read_hiz", sram_d, 16'hFFFF);
                wr_exp = 0; rd_exp = 0;
                check_counts();
                ce_n = 1'b1; oe_n = 1'b1;
                tick(2);
                rst_n = 1'b1;
                tick(3);
                check16("after_reset_hiz", sram_d, 16'hFFFF);
                do_read(18'h00005, 1'b0, 18'h0, 1);

                tick(5);
                check_int("scoreboard_empty", exp_q.size(), 0);
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ap_sram_target.md
# ap_sram_target

Synchronous responder for the external asynchronous-SRAM pin interface. It sits on the chip side of the 18-bit-address, 16-bit-data SRAM bus and emulates the memory device on-FPGA for bring-up and simulation. It samples CE_n/OE_n/WE_n/A/D through synchronizers, commits writes to an internal block RAM, and drives read data back onto the shared bus after a programmable latency. Read and write completions are counted for debug.

## Interface
- ADDR_WIDTH, 18: pin address width.
- DEPTH_LOG2, 10: internal memory is 2^DEPTH_LOG2 x 16 bits. Must satisfy 1 <= DEPTH_LOG2 <= ADDR_WIDTH.
- READ_LATENCY, 2: cycles from read decode to data drive. Must be >= 1.
- iCLK  in  1  system clock; all state changes on the rising edge.
- iRESET_n  in  1  reset; asynchronous, active-low.
- iSRAM_A  in  ADDR_WIDTH  address from initiator.
- ioSRAM_D  inout  16  shared data bus.
- iSRAM_CE_n  in  1  chip enable, active-low.
- iSRAM_OE_n  in  1  output enable, active-low.
- iSRAM_WE_n  in  1  write enable, active-low.
- oWR_COUNT  out  16  committed writes, wraps at 2^16.
- oRD_COUNT  out  16  completed read fetches, wraps at 2^16.

## Operation
- Sampling: CE_n, OE_n, WE_n, A and D each pass through a 2-flop stage. The FSM sees only the stage-2 values sCE_n, sOE_n, sWE_n, sA, sD, all aligned.
- Memory index is sA[DEPTH_LOG2-1:0]. Upper address bits are ignored, so the memory aliases.
- FSM states: IDLE, WRITE, READ_WAIT, READ_DRIVE.
- IDLE:
  - sCE_n=0 and sWE_n=0 -> WRITE.
  - Else sCE_n=0 and sOE_n=0 -> READ_WAIT; latch rd_addr=sA, load cnt=READ_LATENCY.
  - Else stay in IDLE.
- WRITE:
  - Every cycle with sCE_n=0 and sWE_n=0, latch wr_addr=sA and wr_data=sD.
  - On the first cycle with sWE_n=1 or sCE_n=1: write mem[wr_addr]=wr_data, increment oWR_COUNT, go to IDLE.
  - The last values sampled while WE was low are the ones written.
- READ_WAIT:
  - Abort to IDLE if sCE_n=1, sOE_n=1 or sWE_n=0. No count change.
  - Else if sA != rd_addr, relatch rd_addr and reload cnt.
  - Else decrement cnt. When cnt==1: load dout=mem[rd_addr], increment oRD_COUNT, go to READ_DRIVE.
- READ_DRIVE:
  - sWE_n=0 with sCE_n=0 -> WRITE.
  - Else sCE_n=1 or sOE_n=1 -> IDLE.
  - Else sA != rd_addr -> READ_WAIT; relatch rd_addr, reload cnt.
- Bus drive: ioSRAM_D = dout only when state==READ_DRIVE and raw iSRAM_CE_n=0, iSRAM_OE_n=0 and iSRAM_WE_n=1. Otherwise 16'hzzzz.
  - The gating uses the raw pins, so drive stops combinationally when the initiator deasserts.
- WE and OE both low: write takes priority and the bus is never driven.
- Memory contents are not reset. Reads of unwritten locations return an undefined value.

## Timing
- Reset values:
  - State IDLE; cnt 0; dout 16'h0000.
  - oWR_COUNT 0; oRD_COUNT 0.
  - Synchronizer flops: control inputs reset to 1 (inactive), A/D flops to 0.
  - ioSRAM_D is hi-z.
- Reset assertion mid-operation:
  - Bus goes hi-z immediately (asynchronous), state returns to IDLE, counts clear.
  - A write in progress is dropped.
- Pin edges are numbered: pins stable before edge 0.
  - Stage-2 values are valid after edge 1.
  - FSM acts at edge 2.
- Read latency: READ_WAIT entered at edge 2, READ_DRIVE entered at edge 2+READ_LATENCY.
  - Default: data is on the bus after edge 4 and remains until a pin deassert, WE assertion, or address change.
- Write commit: at edge 2 after WE_n (or CE_n) rises at the pins. Data is readable by a read started after that.
- Initiator pin pulses shorter than 2 cycles may be missed. Initiators must hold each phase at least 3 cycles.
- Counter wrap: 16'hFFFF + 1 -> 16'h0000. No saturation.

## Test plan
- Reset: hold iRESET_n=0 with CE_n=OE_n=0 -> ioSRAM_D=zzzz, oWR_COUNT=oRD_COUNT=0; release -> still hi-z until READ_DRIVE.
- Write/readback: write 16'hBEEF to A=18'h00005 (WE low 4 cycles), then read A=5 -> ioSRAM_D=BEEF after edge 4 of read; oWR_COUNT=1, oRD_COUNT=1.
- Aliasing (DEPTH_LOG2=10): write 16'h1234 to A=18'h00403, read A=18'h00003 -> 16'h1234.
- Address change during READ_DRIVE: A=5 (BEEF) -> A=6 holding 16'hCAFE -> bus reflects CAFE after edge 2+READ_LATENCY from the change; oRD_COUNT increments again.
- Contention: CE_n=OE_n=WE_n=0 with D=16'h00AA at A=7 -> bus never driven by the block; mem[7]=00AA after WE_n rises; subsequent read returns 00AA.
- Reset mid-read: in READ_DRIVE, pulse iRESET_n low between edges -> ioSRAM_D hi-z in the same cycle, counts 0, state IDLE.
